// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG-to-AHB-Lite debug bridge.
// JTAG_IDCODE_EN selects whether the IDCODE register exists.
package jtag_pkg;

  localparam int REGISTER_SIZE = 32;
  localparam int IR_SIZE       = 4;
  localparam int STATE_SIZE    = 4;

  typedef enum logic [STATE_SIZE-1:0] {
    TAP_RESET    = 4'h0,
    TAP_IDLE     = 4'h1,
    TAP_SEL_DR   = 4'h2,
    TAP_CAP_DR   = 4'h3,
    TAP_SHIFT_DR = 4'h4,
    TAP_EX1_DR   = 4'h5,
    TAP_PAUSE_DR = 4'h6,
    TAP_EX2_DR   = 4'h7,
    TAP_UPD_DR   = 4'h8,
    TAP_SEL_IR   = 4'h9,
    TAP_CAP_IR   = 4'hA,
    TAP_SHIFT_IR = 4'hB,
    TAP_EX1_IR   = 4'hC,
    TAP_PAUSE_IR = 4'hD,
    TAP_EX2_IR   = 4'hE,
    TAP_UPD_IR   = 4'hF
  } tap_state_e;

  typedef enum logic [2:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_ADDR,
    DR_WDATA,
    DR_RDATA
  } dr_sel_e;

  typedef enum logic [1:0] {
    AHB_IDLE,
    AHB_ADDR,
    AHB_DATA
  } ahb_phase_e;

  localparam logic [IR_SIZE-1:0] OP_BYPASS = 4'b0000;
  localparam logic [IR_SIZE-1:0] OP_IDCODE = 4'b1000;
  localparam logic [IR_SIZE-1:0] OP_ADDR   = 4'b0100;
  localparam logic [IR_SIZE-1:0] OP_WDATA  = 4'b1100;
  localparam logic [IR_SIZE-1:0] OP_RDATA  = 4'b0010;

  localparam logic [REGISTER_SIZE-1:0] IDCODE_VALUE = 32'h1234_5677;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_SIZE-1:0] OP_RESET = OP_IDCODE;
`else
  localparam logic [IR_SIZE-1:0] OP_RESET = OP_BYPASS;
`endif

  // Unknown opcodes fall back to the 1-bit bypass register.
  function automatic dr_sel_e decode_ir(input logic [IR_SIZE-1:0] ir);
    dr_sel_e sel;
    case (ir)
`ifdef JTAG_IDCODE_EN
      OP_IDCODE: sel = DR_IDCODE;
`endif
      OP_ADDR:   sel = DR_ADDR;
      OP_WDATA:  sel = DR_WDATA;
      OP_RDATA:  sel = DR_RDATA;
      default:   sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller, advanced by TMS on rising TCK.
//
// state       | meaning
// TAP_RESET   | Test-Logic-Reset, instruction forced to default
// TAP_IDLE    | Run-Test/Idle
// TAP_SEL_*   | Select-DR/IR scan
// TAP_CAP_*   | Capture-DR/IR, parallel load of shift register
// TAP_SHIFT_* | Shift-DR/IR, TDI -> register -> TDO
// TAP_EX1_*   | Exit1-DR/IR
// TAP_PAUSE_* | Pause-DR/IR
// TAP_EX2_*   | Exit2-DR/IR
// TAP_UPD_*   | Update-DR/IR, action on the exiting edge
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  output tap_state_e state_o
);

  tap_state_e state_q;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q <= TAP_RESET;
    end else begin
      case (state_q)
        TAP_RESET:    state_q <= TMS ? TAP_RESET    : TAP_IDLE;
        TAP_IDLE:     state_q <= TMS ? TAP_SEL_DR   : TAP_IDLE;
        TAP_SEL_DR:   state_q <= TMS ? TAP_SEL_IR   : TAP_CAP_DR;
        TAP_CAP_DR:   state_q <= TMS ? TAP_EX1_DR   : TAP_SHIFT_DR;
        TAP_SHIFT_DR: state_q <= TMS ? TAP_EX1_DR   : TAP_SHIFT_DR;
        TAP_EX1_DR:   state_q <= TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
        TAP_PAUSE_DR: state_q <= TMS ? TAP_EX2_DR   : TAP_PAUSE_DR;
        TAP_EX2_DR:   state_q <= TMS ? TAP_UPD_DR   : TAP_SHIFT_DR;
        TAP_UPD_DR:   state_q <= TMS ? TAP_SEL_DR   : TAP_IDLE;
        TAP_SEL_IR:   state_q <= TMS ? TAP_RESET    : TAP_CAP_IR;
        TAP_CAP_IR:   state_q <= TMS ? TAP_EX1_IR   : TAP_SHIFT_IR;
        TAP_SHIFT_IR: state_q <= TMS ? TAP_EX1_IR   : TAP_SHIFT_IR;
        TAP_EX1_IR:   state_q <= TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
        TAP_PAUSE_IR: state_q <= TMS ? TAP_EX2_IR   : TAP_PAUSE_IR;
        TAP_EX2_IR:   state_q <= TMS ? TAP_UPD_IR   : TAP_SHIFT_IR;
        TAP_UPD_IR:   state_q <= TMS ? TAP_SEL_DR   : TAP_IDLE;
        default:      state_q <= TAP_RESET;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag.sv
// JTAG TAP with IR/DR scan chains and a single-transfer AHB-Lite master, all on TCK.
// JTAG_IDCODE_EN enables the IDCODE register; otherwise opcode 4'b1000 acts as BYPASS.
module jtag
  import jtag_pkg::*;
(
  input  logic                     TCK,
  input  logic                     TRST_N,
  input  logic                     TMS,
  input  logic                     TDI,
  output logic                     TDO,
  input  logic                     HREADY,
  input  logic [REGISTER_SIZE-1:0] HRDATA,
  input  logic                     HRESP,
  output logic                     HWRITE,
  output logic [1:0]               HTRANS,
  output logic [REGISTER_SIZE-1:0] HWDATA,
  output logic [REGISTER_SIZE-1:0] HADDR
);

  tap_state_e tap_state;

  logic [IR_SIZE-1:0]       ir_q;
  logic [IR_SIZE-1:0]       ir_sh_q;
  logic [REGISTER_SIZE-1:0] dr_sh_q;
  logic                     bypass_q;
  logic [REGISTER_SIZE-1:0] addr_q;
  logic [REGISTER_SIZE-1:0] wdata_q;
  logic [REGISTER_SIZE-1:0] rbuf_q;
  logic                     err_q;
  ahb_phase_e               phase_q;
  logic [1:0]               htrans_q;
  logic                     hwrite_q;
  logic                     tdo_q;

  dr_sel_e                  dr_sel;
  logic [REGISTER_SIZE-1:0] capture_val;
  logic                     xfer_req;
  logic                     busy;

  jtag_tap_fsm u_fsm (
    .TCK     (TCK),
    .TRST_N  (TRST_N),
    .TMS     (TMS),
    .state_o (tap_state)
  );

  assign dr_sel   = decode_ir(ir_q);
  assign busy     = (phase_q != AHB_IDLE);
  assign xfer_req = (tap_state == TAP_UPD_DR) &&
                    ((dr_sel == DR_WDATA) || (dr_sel == DR_RDATA));

  always_comb begin
    capture_val = '0;
    case (dr_sel)
      DR_IDCODE: capture_val = IDCODE_VALUE;
      DR_ADDR:   capture_val = addr_q;
      DR_WDATA:  capture_val = wdata_q;
      DR_RDATA:  capture_val = rbuf_q;
      default:   capture_val = '0;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_q     <= OP_RESET;
      ir_sh_q  <= '0;
      dr_sh_q  <= '0;
      bypass_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      err_q    <= 1'b0;
      phase_q  <= AHB_IDLE;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
    end else begin
      case (tap_state)
        TAP_RESET: ir_q <= OP_RESET;
        TAP_CAP_IR: begin
          ir_sh_q <= {1'b0, err_q, 2'b01};
          err_q   <= 1'b0;
        end
        TAP_SHIFT_IR: ir_sh_q <= {TDI, ir_sh_q[IR_SIZE-1:1]};
        TAP_UPD_IR:   ir_q    <= ir_sh_q;
        TAP_CAP_DR: begin
          bypass_q <= 1'b0;
          dr_sh_q  <= capture_val;
        end
        TAP_SHIFT_DR: begin
          bypass_q <= TDI;
          dr_sh_q  <= {TDI, dr_sh_q[REGISTER_SIZE-1:1]};
        end
        TAP_UPD_DR: begin
          if (dr_sel == DR_ADDR) addr_q <= dr_sh_q;
          if ((dr_sel == DR_WDATA) && !busy) wdata_q <= dr_sh_q;
        end
        default: ;
      endcase

      // Error-setting assignments come after the Capture-IR clear so they win.
      if (tap_state == TAP_RESET) begin
        phase_q  <= AHB_IDLE;
        htrans_q <= HTRANS_IDLE;
        hwrite_q <= 1'b0;
      end else begin
        case (phase_q)
          AHB_IDLE: begin
            if (xfer_req) begin
              phase_q  <= AHB_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              hwrite_q <= (dr_sel == DR_WDATA);
            end
          end
          AHB_ADDR: begin
            if (xfer_req) err_q <= 1'b1;
            if (HREADY) begin
              phase_q  <= AHB_DATA;
              htrans_q <= HTRANS_IDLE;
            end
          end
          AHB_DATA: begin
            if (xfer_req || HRESP) err_q <= 1'b1;
            if (HREADY) begin
              phase_q  <= AHB_IDLE;
              hwrite_q <= 1'b0;
              if (!hwrite_q) rbuf_q <= HRDATA;
            end
          end
          default: begin
            phase_q  <= AHB_IDLE;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_q <= 1'b0;
    end else if (tap_state == TAP_SHIFT_IR) begin
      tdo_q <= ir_sh_q[0];
    end else if (tap_state == TAP_SHIFT_DR) begin
      tdo_q <= (dr_sel == DR_BYPASS) ? bypass_q : dr_sh_q[0];
    end else begin
      tdo_q <= 1'b0;
    end
  end

  assign TDO    = tdo_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HADDR  = addr_q;
  assign HWDATA = wdata_q;

endmodule

// File: tb/tb_jtag.sv
// Directed bench for the JTAG-to-AHB bridge; expectations follow JTAG_IDCODE_EN.
module tb_jtag;
  import jtag_pkg::*;

  logic        TCK    = 1'b0;
  logic        TRST_N = 1'b1;
  logic        TMS    = 1'b1;
  logic        TDI    = 1'b0;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;
  logic [31:0] HRDATA = 32'h0;
  logic        TDO;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HADDR;

  int checks = 0;
  int errors = 0;

  always #5 TCK = ~TCK;

  jtag dut (
    .TCK    (TCK),
    .TRST_N (TRST_N),
    .TMS    (TMS),
    .TDI    (TDI),
    .TDO    (TDO),
    .HREADY (HREADY),
    .HRDATA (HRDATA),
    .HRESP  (HRESP),
    .HWRITE (HWRITE),
    .HTRANS (HTRANS),
    .HWDATA (HWDATA),
    .HADDR  (HADDR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic tms);
    @(negedge TCK); #1;
    TMS = tms;
    TDI = 1'b0;
    @(posedge TCK); #1;
  endtask

  task automatic cyc(input logic tms, input logic tdi, output logic tdo);
    @(negedge TCK); #1;
    TMS = tms;
    TDI = tdi;
    tdo = TDO;
    @(posedge TCK); #1;
  endtask

  // From Run-Test/Idle: capture, shift n bits LSB first, update, back to idle.
  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = '0;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < n; i++) begin
      cyc(i == n - 1, din[i], b);
      dout[i] = b;
    end
    step(1'b1); step(1'b0);
  endtask

  task automatic shift_ir(input logic [3:0] op, output logic [3:0] cap);
    logic b;
    cap = '0;
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, op[i], b);
      cap[i] = b;
    end
    step(1'b1); step(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  c;

    #1 TRST_N = 1'b0;
    #1;
    check("rst_tdo",    32'(TDO),    32'h0);
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_haddr",  HADDR,       32'h0);
    check("rst_hwdata", HWDATA,      32'h0);
    @(negedge TCK); #2 TRST_N = 1'b1;

    // Wander into Shift-DR, then five TMS=1 clocks must reach Test-Logic-Reset.
    step(1'b0); step(1'b1); step(1'b0); step(1'b0);
    repeat (5) step(1'b1);
    check("tlr_state", 32'(dut.tap_state), 32'(TAP_RESET));
    step(1'b0);

    shift_dr(32'hFFFF_FFFF, 32, d);
`ifdef JTAG_IDCODE_EN
    check("idcode_read", d, 32'h1234_5677);
`else
    check("idcode_read", d, 32'hFFFF_FFFE);
`endif

    shift_dr(32'h89AB_CDEF, 32, d);
`ifdef JTAG_IDCODE_EN
    check("idcode_upd_shift", d, 32'h1234_5677);
`else
    check("idcode_upd_shift", d, 32'h1357_9BDE);
`endif
    check("idcode_no_ahb0", 32'(HTRANS), 32'h0);
    step(1'b0);
    check("idcode_no_ahb1", 32'(HTRANS), 32'h0);
    shift_dr(32'h0, 32, d);
`ifdef JTAG_IDCODE_EN
    check("idcode_reread", d, 32'h1234_5677);
`else
    check("idcode_reread", d, 32'h0);
`endif

    shift_ir(OP_BYPASS, c);
    check("ir_capture", 32'(c), 32'h1);

    shift_dr(32'h0000_00A5, 8, d);
    check("bypass_delay", d, 32'h0000_004A);

    shift_ir(OP_ADDR, c);
    shift_dr(32'h89AB_CDEF, 32, d);
    check("addr_capture", d, 32'h0);
    check("addr_haddr", HADDR, 32'h89AB_CDEF);
    check("addr_no_ahb", 32'(HTRANS), 32'h0);

    shift_ir(OP_WDATA, c);
    check("wr_ir_cap", 32'(c), 32'h1);
    shift_dr(32'h0000_0055, 32, d);
    check("wr_capture", d, 32'h0);
    check("wr_aph_htrans", 32'(HTRANS), 32'h2);
    check("wr_aph_hwrite", 32'(HWRITE), 32'h1);
    check("wr_aph_haddr",  HADDR,       32'h89AB_CDEF);
    step(1'b0);
    check("wr_dph_htrans", 32'(HTRANS), 32'h0);
    check("wr_dph_hwdata", HWDATA,      32'h55);
    step(1'b0);
    check("wr_done_hwrite", 32'(HWRITE), 32'h0);

    HRDATA = 32'h0000_F00F;
    shift_ir(OP_RDATA, c);
    shift_dr(32'h0, 32, d);
    check("rd_capture0", d, 32'h0);
    check("rd_aph_htrans", 32'(HTRANS), 32'h2);
    check("rd_aph_hwrite", 32'(HWRITE), 32'h0);
    step(1'b0);
    check("rd_dph_htrans", 32'(HTRANS), 32'h0);
    shift_dr(32'h0, 32, d);
    check("rd_buffer", d, 32'h0000_F00F);
    step(1'b0); step(1'b0);

    HRESP  = 1'b1;
    HRDATA = 32'h0000_1234;
    shift_dr(32'h0, 32, d);
    step(1'b0); step(1'b0);
    HRESP = 1'b0;
    shift_ir(OP_RDATA, c);
    check("err_capture", 32'(c), 32'h5);
    shift_ir(OP_WDATA, c);
    check("err_cleared", 32'(c), 32'h1);

    // A second WDATA update while the address phase is stalled is dropped.
    HREADY = 1'b0;
    shift_dr(32'h0000_00AA, 32, d);
    step(1'b0);
    check("stall_hold", 32'(HTRANS), 32'h2);
    shift_dr(32'h0000_00BB, 32, d);
    check("stall_hold2", 32'(HTRANS), 32'h2);
    HREADY = 1'b1;
    step(1'b0);
    check("busy_wdata", HWDATA, 32'h0000_00AA);
    step(1'b0);
    shift_ir(OP_WDATA, c);
    check("busy_err", 32'(c), 32'h5);

    step(1'b1); step(1'b0); step(1'b0);
    step(1'b0);
    @(negedge TCK); #2;
    check("sdr_tdo_pre", 32'(TDO), 32'h1);
    TRST_N = 1'b0;
    #1;
    check("sdr_rst_tdo",    32'(TDO), 32'h0);
    check("sdr_rst_haddr",  HADDR,    32'h0);
    check("sdr_rst_hwdata", HWDATA,   32'h0);
    check("sdr_rst_state",  32'(dut.tap_state), 32'(TAP_RESET));
    @(negedge TCK); #2 TRST_N = 1'b1;
    step(1'b0);

    shift_ir(OP_ADDR, c);
    shift_dr(32'h0000_0100, 32, d);
    shift_ir(OP_WDATA, c);
    HREADY = 1'b0;
    shift_dr(32'h0000_0077, 32, d);
    step(1'b0);
    check("aph_hold_htrans", 32'(HTRANS), 32'h2);
    check("aph_hold_haddr",  HADDR,       32'h0000_0100);
    @(negedge TCK); #2 TRST_N = 1'b0;
    #1;
    check("aph_rst_htrans", 32'(HTRANS), 32'h0);
    check("aph_rst_hwrite", 32'(HWRITE), 32'h0);
    check("aph_rst_haddr",  HADDR,       32'h0);
    check("aph_rst_hwdata", HWDATA,      32'h0);
    @(negedge TCK); #2 TRST_N = 1'b1;
    HREADY = 1'b1;
    step(1'b0);

    // TMS-driven Test-Logic-Reset aborts a stalled transfer but keeps ADDR/WDATA.
    shift_ir(OP_ADDR, c);
    shift_dr(32'h0000_0200, 32, d);
    shift_ir(OP_WDATA, c);
    HREADY = 1'b0;
    shift_dr(32'h0000_0033, 32, d);
    check("tlr_pre_htrans", 32'(HTRANS), 32'h2);
    repeat (5) step(1'b1);
    check("tlr_abort_htrans", 32'(HTRANS), 32'h0);
    check("tlr_keep_haddr",   HADDR,       32'h0000_0200);
    check("tlr_keep_hwdata",  HWDATA,      32'h0000_0033);
    HREADY = 1'b1;
    step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
